// File: rtl/pio_pattern_sequencer.sv
// pio_pattern_sequencer: plays a small pattern table onto the PIO s1 slave
// through an Avalon-MM master port, one entry every INTERVAL clocks, once or
// looping. Software fills the table and controls playback via a config slave.
module pio_pattern_sequencer #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy,
    output logic        done_irq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_INTERVAL = 3'd2;
    localparam logic [2:0] ADDR_DATA     = 3'd3;
    localparam logic [2:0] ADDR_LAST     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DIV_W-1:0]        interval_q, interval_d;
    logic [DIV_W-1:0]        tick_q, tick_d;
    logic                    loop_q, loop_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_W-1:0]       last_q, last_d;
    logic [DATA_W-1:0]       table_q [DEPTH];
    logic [DATA_W-1:0]       table_d [DEPTH];

    logic cfg_wr_s, ctrl_wr_s, status_wr_s, interval_wr_s, data_wr_s;
    logic start_s, stop_s, clear_s, done_clr_s;
    logic full_s, empty_s, last_idx_s;
    logic unused_wdata_s;

    // Gap length minus one; an INTERVAL of 0 behaves like 1 (back-to-back strobes).
    function automatic logic [DIV_W-1:0] tick_load(input logic [DIV_W-1:0] iv);
        if (iv == {DIV_W{1'b0}}) begin
            tick_load = {DIV_W{1'b0}};
        end else begin
            tick_load = iv - DIV_W'(1);
        end
    endfunction

    assign cfg_wr_s      = cfg_chipselect & ~cfg_write_n;
    assign ctrl_wr_s     = cfg_wr_s && (cfg_address == ADDR_CTRL);
    assign status_wr_s   = cfg_wr_s && (cfg_address == ADDR_STATUS);
    assign interval_wr_s = cfg_wr_s && (cfg_address == ADDR_INTERVAL);
    assign data_wr_s     = cfg_wr_s && (cfg_address == ADDR_DATA);
    assign start_s       = ctrl_wr_s & cfg_writedata[0];
    assign stop_s        = ctrl_wr_s & cfg_writedata[2];
    assign clear_s       = ctrl_wr_s & cfg_writedata[3];
    assign done_clr_s    = status_wr_s & cfg_writedata[1];
    assign full_s        = (count_q == DEPTH_C);
    assign empty_s       = (count_q == {CNT_W{1'b0}});
    // Compared against the live count so entries appended mid-run get played.
    assign last_idx_s    = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
    assign unused_wdata_s = ^cfg_writedata;

    // State and datapath registers; the table is cleared too for determinism.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            wr_ptr_q   <= {IDX_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            interval_q <= {DIV_W{1'b0}};
            tick_q     <= {DIV_W{1'b0}};
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            last_q     <= {DATA_W{1'b0}};
            table_q    <= '{default: {DATA_W{1'b0}}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            interval_q <= interval_d;
            tick_q     <= tick_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
            table_q    <= table_d;
        end
    end

    // Config-side registers: table fill, CLEAR, overflow flag, INTERVAL, LOOP.
    always_comb begin
        table_d    = table_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        if (data_wr_s) begin
            if (!full_s) begin
                table_d[wr_ptr_q] = cfg_writedata[DATA_W-1:0];
                wr_ptr_d          = wr_ptr_q + IDX_W'(1);
                count_d           = count_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (clear_s && (state_q == ST_IDLE)) begin
            wr_ptr_d = {IDX_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
        end else if (status_wr_s && cfg_writedata[4]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (interval_wr_s) begin
            interval_d = cfg_writedata[DIV_W-1:0];
        end else begin
            interval_d = interval_q;
        end
        if (ctrl_wr_s) begin
            loop_d = cfg_writedata[1];
        end else begin
            loop_d = loop_q;
        end
    end

    // Sequencer next state; a done set on the final strobe beats a STATUS clear.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        last_d  = last_q;
        if (done_clr_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_s && !stop_s && !empty_s) begin
                    state_d = ST_STROBE;
                    idx_d   = {IDX_W{1'b0}};
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STROBE: begin
                last_d = table_q[idx_q];
                tick_d = tick_load(interval_q);
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (last_idx_s && !loop_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (last_idx_s) begin
                        idx_d = {IDX_W{1'b0}};
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (tick_d != {DIV_W{1'b0}}) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_STROBE;
                    end
                end
            end
            ST_WAIT: begin
                tick_d = tick_q - DIV_W'(1);
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (tick_q == DIV_W'(1)) begin
                    state_d = ST_STROBE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Master-port and status outputs decoded straight from registered state.
    always_comb begin
        pio_address = 2'd0;
        busy        = (state_q != ST_IDLE);
        done_irq    = done_q;
        if (state_q == ST_STROBE) begin
            pio_chipselect = 1'b1;
            pio_write_n    = 1'b0;
            pio_writedata  = {{(32-DATA_W){1'b0}}, table_q[idx_q]};
        end else begin
            pio_chipselect = 1'b0;
            pio_write_n    = 1'b1;
            pio_writedata  = 32'd0;
        end
    end

    // Zero-latency config read mux.
    always_comb begin
        cfg_readdata = 32'd0;
        case (cfg_address)
            ADDR_STATUS: begin
                cfg_readdata[0]           = (state_q != ST_IDLE);
                cfg_readdata[1]           = done_q;
                cfg_readdata[2]           = full_s;
                cfg_readdata[3]           = empty_s;
                cfg_readdata[4]           = ovf_q;
                cfg_readdata[8 +: CNT_W]  = count_q;
            end
            ADDR_INTERVAL: cfg_readdata[DIV_W-1:0]  = interval_q;
            ADDR_LAST:     cfg_readdata[DATA_W-1:0] = last_q;
            default:       cfg_readdata = 32'd0;
        endcase
    end

endmodule

// File: doc/pio_pattern_sequencer.md
Name: pio_pattern_sequencer

Overview:
Avalon-MM controller that sequences the 14-bit output PIO in the MYO FPGA system without Nios II involvement per step. Software loads a small pattern table through a configuration slave, sets an interval and starts the block. The block then acts as an Avalon-MM master on the PIO s1 port and writes one pattern entry every INTERVAL clocks, either once or looping. It drives that port directly; no other master shares it while the block is in use.

Parameters:
DATA_W, 14, PIO data width; pattern entry width.
DEPTH, 8, pattern table entries; must be a power of 2.
DIV_W, 16, width of the interval register and counter.

Ports:
clk  input  1  system clock
reset_n  input  1  reset
cfg_address  input  3  config slave word address
cfg_chipselect  input  1  config slave select
cfg_write_n  input  1  config write strobe, active-low
cfg_writedata  input  32  config write data
cfg_readdata  output  32  config read data, combinational from address, zero latency
pio_address  output  2  PIO slave address, constant 0
pio_chipselect  output  1  PIO select, high only on a write strobe
pio_write_n  output  1  PIO write, active-low, low only on a write strobe
pio_writedata  output  32  {(32-DATA_W)'b0, entry}
busy  output  1  sequencer running
done_irq  output  1  level, equals the STATUS.done sticky bit

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
  - All registers clear: FSM=IDLE, count=0, wr_ptr=0, idx=0, interval=0, loop=0, done=0, ovf=0, last=0.
  - Outputs during reset: pio_chipselect=0, pio_write_n=1, pio_writedata=0, busy=0, done_irq=0.
- Register map (a config write = cfg_chipselect & ~cfg_write_n):
  - 0 CTRL, write-only, reads 0.
    - bit0 START
    - bit1 LOOP, latched on every CTRL write
    - bit2 STOP
    - bit3 CLEAR, honoured only in IDLE; sets count=0, wr_ptr=0, ovf=0
  - 1 STATUS
    - Read layout: [0] busy, [1] done, [2] full, [3] empty, [4] ovf, [11:8] count.
    - Writing 1 to bit1 clears done; writing 1 to bit4 clears ovf.
  - 2 INTERVAL: R/W, DIV_W bits, zero-extended on read. Effective value is max(INTERVAL,1).
  - 3 DATA
    - Write: if count<DEPTH, table[wr_ptr]<=writedata[DATA_W-1:0], wr_ptr++, count++. If count==DEPTH, write is dropped and ovf<=1.
    - Reads 0.
  - 4 LAST: read-only, last entry written to the PIO.
  - 5–7: read 0, writes ignored.
  - full = (count==DEPTH); empty = (count==0).
  - The table is non-destructive; playback does not consume entries.
- FSM states: IDLE, STROBE, WAIT.
  - IDLE -> STROBE on START with count!=0 and no STOP in the same write. Action: idx<=0, done<=0.
    - START with count==0 is ignored: stays IDLE, done unchanged.
  - STROBE, exactly one cycle:
    - Drive pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata=table[idx] zero-extended.
    - Update last<=table[idx]; load tick<=max(INTERVAL,1)-1.
    - Next state, evaluated in order:
      - If STOP is being written this cycle: go to IDLE; the strobe still completes.
      - Else if idx==count-1 and loop=0: go to IDLE and set done<=1.
      - Else if idx==count-1 and loop=1: idx<=0.
      - Otherwise idx++.
      - In both non-final cases: go to WAIT if tick load value!=0, else straight to STROBE.
  - WAIT: tick decrements each cycle; at tick==1 go to STROBE.
- Timing:
  - Strobe-to-strobe spacing is exactly max(INTERVAL,1) clocks.
  - INTERVAL is sampled at each STROBE, so a mid-run change takes effect on the next gap.
  - First strobe occurs in the cycle after the START write cycle.
- busy = (FSM!=IDLE).
- STOP in WAIT: go to IDLE next cycle, no further strobe, done not set.
- START while busy: ignored. LOOP and STOP bits in the same write still apply.
- DATA writes while busy are accepted if not full.
  - Playback compares idx against the live count, so appended entries play on the current or next pass.
- CLEAR while busy is ignored.
- Simultaneous STATUS done-clear and done-set in the same cycle: set wins.
- Reset mid-run aborts immediately; the table contents are not guaranteed after reset.

Test Plan:
- Push 0x0001, 0x2AAA, 0x3FFF; INTERVAL=4; CTRL=0x1 -> three strobes at cycles S, S+4, S+8 with writedata 0x00000001, 0x00002AAA, 0x00003FFF. After the third strobe: busy=0, done_irq=1, LAST=0x3FFF.
- Same table, INTERVAL=0; CTRL=0x3 (loop); STOP after 7 strobes -> strobes every cycle in order 1, 2AAA, 3FFF, 1, … Stops after the in-flight strobe; done=0.
- Push 9 entries with DEPTH=8 -> STATUS reads full=1, ovf=1, count=8; the 9th value never appears on the PIO. Write STATUS bit4 -> ovf=0.
- CTRL=0x1 with empty table -> no strobe, busy stays 0, done stays 0. CTRL=0x8 while busy -> count unchanged.
- Run with INTERVAL=10; write STOP during WAIT -> no further strobe, busy=0 one cycle later. Repeat, asserting reset_n low mid-WAIT -> outputs go to reset values asynchronously.
- Done set on the final strobe in the same cycle as a STATUS write of 0x2 -> done reads 1 afterwards. A second 0x2 write -> done_irq=0.
